// File: rtl/l1_mem_pkg.sv
// Shared definitions for the L1 memory-port arbiter: FSM states, requester IDs
// and default bus widths.
package l1_mem_pkg;

  localparam int unsigned L1_ADDR_WIDTH = 32;
  localparam int unsigned L1_LINE_WIDTH = 128;
  localparam int unsigned L1_DATA_WIDTH = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_RD_ADDR,
    D_RD_DATA,
    D_WR_ADDR
  } arb_state_e;

endpackage

// File: rtl/l1_rr_picker.sv
// Two-input I/D picker. Round-robin on last_grant by default; fixed D priority
// when L1_ARB_DCACHE_PRIORITY_EN is defined.
module l1_rr_picker
  import l1_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic update_i,
  output logic grant_d_o
);

`ifdef L1_ARB_DCACHE_PRIORITY_EN
  logic unused_prio;

  assign grant_d_o   = req_d_i;
  assign unused_prio = ^{clk, rst, req_i_i, update_i};
`else
  logic last_grant_q;
  logic last_grant_d;

  // On a tie the side that did not win last time gets the port.
  assign grant_d_o    = req_d_i & (~req_i_i | (last_grant_q == REQ_I));
  assign last_grant_d = update_i ? grant_d_o : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one memory port between the I-cache and D-cache, holding each grant
// until its transaction completes. Optional macro: L1_ARB_DCACHE_PRIORITY_EN.
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = L1_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = L1_LINE_WIDTH,
  parameter int unsigned DATA_WIDTH = L1_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    icache_mem_req,
  input  logic [ADDR_WIDTH-1:0]   icache_mem_addr,
  output logic                    mem_icache_addrOK,
  output logic                    mem_icache_dataOK,
  input  logic                    dcache_mem_req,
  input  logic                    dcache_mem_wr,
  input  logic [ADDR_WIDTH-1:0]   dcache_mem_addr,
  input  logic [DATA_WIDTH-1:0]   dcache_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dcache_mem_wstrb,
  output logic                    mem_dcache_addrOK,
  output logic                    mem_dcache_dataOK,
  output logic [LINE_WIDTH-1:0]   mem_rdata_line,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_addrOK,
  input  logic                    mem_dataOK,
  input  logic [LINE_WIDTH-1:0]   mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       pick_en;
  logic       grant_d;

  l1_rr_picker u_picker (
    .clk       (clk),
    .rst       (rst),
    .req_i_i   (icache_mem_req),
    .req_d_i   (dcache_mem_req),
    .update_i  (pick_en),
    .grant_d_o (grant_d)
  );

  assign mem_rdata_line = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In *_ADDR states mem_req follows the owner's req, so a dropped req
  // aborts back to IDLE without a transaction reaching memory.
  always_comb begin
    state_d           = state_q;
    pick_en           = 1'b0;
    mem_req           = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    mem_wstrb         = '0;
    mem_icache_addrOK = 1'b0;
    mem_icache_dataOK = 1'b0;
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (icache_mem_req || dcache_mem_req) begin
          pick_en = 1'b1;
          if (grant_d == REQ_D) begin
            state_d = dcache_mem_wr ? D_WR_ADDR : D_RD_ADDR;
          end else begin
            state_d = I_ADDR;
          end
        end
      end

      I_ADDR: begin
        mem_req           = icache_mem_req;
        mem_addr          = icache_mem_addr;
        mem_icache_addrOK = mem_addrOK;
        if (!icache_mem_req) begin
          state_d = IDLE;
        end else if (mem_addrOK) begin
          state_d = I_DATA;
        end
      end

      I_DATA: begin
        mem_icache_dataOK = mem_dataOK;
        if (mem_dataOK) begin
          state_d = IDLE;
        end
      end

      D_RD_ADDR: begin
        mem_req           = dcache_mem_req;
        mem_wr            = dcache_mem_wr;
        mem_addr          = dcache_mem_addr;
        mem_dcache_addrOK = mem_addrOK;
        if (!dcache_mem_req) begin
          state_d = IDLE;
        end else if (mem_addrOK) begin
          state_d = D_RD_DATA;
        end
      end

      D_RD_DATA: begin
        mem_dcache_dataOK = mem_dataOK;
        if (mem_dataOK) begin
          state_d = IDLE;
        end
      end

      D_WR_ADDR: begin
        mem_req           = dcache_mem_req;
        mem_wr            = dcache_mem_wr;
        mem_addr          = dcache_mem_addr;
        mem_wdata         = dcache_mem_wdata;
        mem_wstrb         = dcache_mem_wstrb;
        mem_dcache_addrOK = mem_addrOK;
        if (!dcache_mem_req || mem_addrOK) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_l1_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ireq, dreq, dwr, maok, mdok;
  logic [31:0]  iaddr, daddr, dwdata;
  logic [3:0]   dwstrb;
  logic [127:0] mrdata;
  logic         i_aok, i_dok, d_aok, d_dok, m_req, m_wr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic [127:0] rline;

  int checks   = 0;
  int failures = 0;

  l1_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_mem_req    (ireq),
    .icache_mem_addr   (iaddr),
    .mem_icache_addrOK (i_aok),
    .mem_icache_dataOK (i_dok),
    .dcache_mem_req    (dreq),
    .dcache_mem_wr     (dwr),
    .dcache_mem_addr   (daddr),
    .dcache_mem_wdata  (dwdata),
    .dcache_mem_wstrb  (dwstrb),
    .mem_dcache_addrOK (d_aok),
    .mem_dcache_dataOK (d_dok),
    .mem_rdata_line    (rline),
    .mem_req           (m_req),
    .mem_wr            (m_wr),
    .mem_addr          (m_addr),
    .mem_wdata         (m_wdata),
    .mem_wstrb         (m_wstrb),
    .mem_addrOK        (maok),
    .mem_dataOK        (mdok),
    .mem_rdata         (mrdata)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] obs_vec();
    return {m_req, m_wr, m_addr, m_wdata, m_wstrb, i_aok, i_dok, d_aok, d_dok};
  endfunction

  task automatic idle_inputs();
    ireq = 1'b0; dreq = 1'b0; dwr = 1'b0; maok = 1'b0; mdok = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0; dwstrb = '0; mrdata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    mdok = 1'b1; maok = 1'b1; mrdata = {4{32'h1234_5678}};
    #1;
    checks++;
    if (obs_vec() !== 74'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs_vec());
    end
    checks++;
    if (rline !== {4{32'h1234_5678}}) begin
      failures++; $display("FAIL reset_rdata_passthru got=%h exp=%h", rline, {4{32'h1234_5678}});
    end
    @(negedge clk);
    rst = 1'b0;
    ireq = 1'b1; dreq = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 74'h0) begin
      failures++; $display("FAIL idle_outputs got=%h exp=0", obs_vec());
    end
    pulse_reset();
  endtask

  task automatic test_i_only();
    logic e_req;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      ireq = (c <= 6); iaddr = 32'h1000;
      maok = (c == 3); mdok = (c == 6); mrdata = {4{32'hA5A5_A5A5}};
      #1;
      e_req = (c >= 1 && c <= 3);
      checks++;
      if ({m_req, m_wr} !== {e_req, 1'b0}) begin
        failures++; $display("FAIL i_only_req_wr c=%0d got=%b%b exp=%b0", c, m_req, m_wr, e_req);
      end
      checks++;
      if (m_addr !== (e_req ? 32'h1000 : 32'h0)) begin
        failures++; $display("FAIL i_only_addr c=%0d got=%h", c, m_addr);
      end
      checks++;
      if ({i_aok, i_dok, d_aok, d_dok} !== {c == 3, c == 6, 2'b00}) begin
        failures++; $display("FAIL i_only_oks c=%0d got=%b%b%b%b", c, i_aok, i_dok, d_aok, d_dok);
      end
      if (c == 6) begin
        checks++;
        if (rline !== {4{32'hA5A5_A5A5}}) begin
          failures++; $display("FAIL i_only_rdata got=%h", rline);
        end
      end
    end
  endtask

  task automatic test_d_write();
    logic e_req;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      dreq = (c <= 2); dwr = (c <= 2); daddr = 32'h2004;
      dwdata = 32'hDEAD_BEEF; dwstrb = 4'hF;
      maok = (c == 2); mdok = (c == 3);
      #1;
      e_req = (c == 1 || c == 2);
      checks++;
      if ({m_req, m_wr} !== {e_req, e_req}) begin
        failures++; $display("FAIL d_write_req_wr c=%0d got=%b%b exp=%b%b", c, m_req, m_wr, e_req, e_req);
      end
      checks++;
      if ({m_addr, m_wdata, m_wstrb} !== (e_req ? {32'h2004, 32'hDEAD_BEEF, 4'hF} : 68'h0)) begin
        failures++; $display("FAIL d_write_payload c=%0d got=%h %h %h", c, m_addr, m_wdata, m_wstrb);
      end
      checks++;
      if ({i_aok, i_dok, d_aok, d_dok} !== {2'b00, c == 2, 1'b0}) begin
        failures++; $display("FAIL d_write_oks c=%0d got=%b%b%b%b", c, i_aok, i_dok, d_aok, d_dok);
      end
    end
    idle_inputs();
  endtask

  // Simultaneous requests from reset: D first, I after D's read completes.
  task automatic test_both_and_rd_data();
    pulse_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      ireq = (c <= 4); iaddr = 32'h3000;
      dreq = (c <= 4); dwr = (c >= 3); daddr = (c >= 3) ? 32'h5000 : 32'h4000;
      maok = (c == 1); mdok = (c == 2); mrdata = {4{32'h0BAD_F00D}};
      #1;
      if (c == 1) begin
        checks++;
        if ({m_req, m_wr, m_addr, d_aok, i_aok} !== {2'b10, 32'h4000, 2'b10}) begin
          failures++; $display("FAIL both_d_first got=%b%b %h %b%b", m_req, m_wr, m_addr, d_aok, i_aok);
        end
      end
      if (c == 2) begin
        checks++;
        if ({m_req, i_dok, d_dok} !== 3'b001) begin
          failures++; $display("FAIL rd_data_only_d got req=%b idok=%b ddok=%b exp 0 0 1", m_req, i_dok, d_dok);
        end
      end
      if (c == 3) begin
        checks++;
        if (obs_vec() !== 74'h0) begin
          failures++; $display("FAIL both_bubble got=%h exp=0", obs_vec());
        end
      end
      if (c == 4) begin
        checks++;
`ifdef L1_ARB_DCACHE_PRIORITY_EN
        if ({m_req, m_wr, m_addr} !== {2'b11, 32'h5000}) begin
          failures++; $display("FAIL prio_d_rerequest got=%b%b %h exp=11 5000", m_req, m_wr, m_addr);
        end
`else
        if ({m_req, m_wr, m_addr} !== {2'b10, 32'h3000}) begin
          failures++; $display("FAIL rr_i_after_d got=%b%b %h exp=10 3000", m_req, m_wr, m_addr);
        end
`endif
      end
      if (c == 5) begin
        checks++;
        if (m_req !== 1'b0) begin
          failures++; $display("FAIL both_abort_req got=%b exp=0", m_req);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      ireq = (c <= 1); iaddr = 32'h6000;
      dreq = (c >= 3 && c <= 5); dwr = 1'b0; daddr = 32'h7000;
      maok = (c == 4); mdok = (c == 5);
      #1;
      if (c == 2) begin
        checks++;
        if ({m_req, i_aok, i_dok} !== 3'b000) begin
          failures++; $display("FAIL abort_no_addrok got req=%b aok=%b dok=%b exp 000", m_req, i_aok, i_dok);
        end
      end
      if (c == 4) begin
        checks++;
        if ({m_req, m_addr, d_aok} !== {1'b1, 32'h7000, 1'b1}) begin
          failures++; $display("FAIL abort_next_served got=%b %h %b", m_req, m_addr, d_aok);
        end
      end
      if (c == 5) begin
        checks++;
        if ({d_dok, i_dok, m_req} !== 3'b100) begin
          failures++; $display("FAIL abort_next_data got=%b%b%b exp=100", d_dok, i_dok, m_req);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid();
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      ireq = 1'b1; iaddr = 32'h8000; maok = (c == 1); mdok = (c == 2);
    end
    #1;
    checks++;
    if (i_dok !== 1'b1) begin
      failures++; $display("FAIL rst_mid_in_data got=%b exp=1", i_dok);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 74'h0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      dreq = (c <= 1); dwr = 1'b1; daddr = 32'h9008; dwdata = 32'h0102_0304; dwstrb = 4'h3;
      maok = (c == 1);
      #1;
      if (c == 1) begin
        checks++;
        if ({m_req, m_wr, m_addr, m_wdata, m_wstrb, d_aok} !== {2'b11, 32'h9008, 32'h0102_0304, 4'h3, 1'b1}) begin
          failures++; $display("FAIL rst_mid_d_write got=%h", obs_vec());
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int owner;  // 0 none, 1 I, 2 D
    bit data_ph, own_wr, last_d, win_d, i_done, d_done, i_drop, d_drop;
    logic e_req, e_wr, e_ia, e_id, e_da, e_dd;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [73:0] exp_v;
    pulse_reset();
    owner = 0; data_ph = 0; own_wr = 0; last_d = 0; i_done = 0; d_done = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      i_drop = 0; d_drop = 0;
      if (i_done) begin ireq = 0; i_done = 0; end
      else if (ireq && owner == 1 && !data_ph && $urandom_range(0, 15) == 0) begin ireq = 0; i_drop = 1; end
      if (!ireq && !i_drop && $urandom_range(0, 2) == 0) begin
        ireq = 1; iaddr = $urandom & 32'hFFFF_FFF0;
      end
      if (d_done) begin dreq = 0; d_done = 0; end
      else if (dreq && owner == 2 && !data_ph && $urandom_range(0, 15) == 0) begin dreq = 0; d_drop = 1; end
      if (!dreq && !d_drop && $urandom_range(0, 2) == 0) begin
        dreq = 1; dwr = $urandom_range(0, 1); daddr = $urandom;
        dwdata = $urandom; dwstrb = 4'($urandom);
      end
      e_req = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_ia = 0; e_id = 0; e_da = 0; e_dd = 0;
      if (owner == 1 && !data_ph) begin e_req = ireq; e_addr = iaddr; end
      if (owner == 2 && !data_ph) begin
        e_req = dreq; e_wr = dwr; e_addr = daddr;
        if (own_wr) begin e_wdata = dwdata; e_wstrb = dwstrb; end
      end
      maok = e_req && ($urandom_range(0, 1) == 1);
      mdok = ($urandom_range(0, 2) == 0);
      mrdata = {$urandom, $urandom, $urandom, $urandom};
      if (owner == 1) begin e_ia = !data_ph && maok; e_id = data_ph && mdok; end
      if (owner == 2) begin e_da = !data_ph && maok; e_dd = data_ph && mdok; end
      exp_v = {e_req, e_wr, e_addr, e_wdata, e_wstrb, e_ia, e_id, e_da, e_dd};
      #1;
      checks++;
      if (obs_vec() !== exp_v) begin
        failures++; $display("FAIL random_outputs n=%0d got=%h exp=%h", n, obs_vec(), exp_v);
      end
      checks++;
      if (rline !== mrdata) begin
        failures++; $display("FAIL random_rdata n=%0d got=%h exp=%h", n, rline, mrdata);
      end
      if (owner == 0) begin
        if (ireq || dreq) begin
`ifdef L1_ARB_DCACHE_PRIORITY_EN
          win_d = dreq;
`else
          win_d = (ireq && dreq) ? !last_d : dreq;
`endif
          last_d = win_d; owner = win_d ? 2 : 1; own_wr = win_d && dwr; data_ph = 0;
        end
      end else if (!data_ph) begin
        if (!(owner == 1 ? ireq : dreq)) owner = 0;
        else if (maok) begin
          if (own_wr) begin owner = 0; d_done = 1; end
          else data_ph = 1;
        end
      end else if (mdok) begin
        if (owner == 1) i_done = 1; else d_done = 1;
        owner = 0; data_ph = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_both_and_rd_data();
    test_abort();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
